// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared types and constants for the data-memory arbiter.
//   arb_state_t          - arbiter mode (BOOT = loader only, RUN = CPU priority)
//   MMIO_ADDR            - MMIO register address that the arbiter passes through
//                          to the memory side untouched
//   DEFAULT_STARVE_LIMIT - default number of loader wait cycles before the
//                          loader is forced a grant
package mem_arbiter_pkg;

    typedef enum logic {
        ST_BOOT = 1'b0,
        ST_RUN  = 1'b1
    } arb_state_t;

    localparam logic [31:0] MMIO_ADDR            = 32'h4000_0010;
    localparam int          DEFAULT_STARVE_LIMIT = 4;

endpackage

// File: rtl/sat_counter.sv
// sat_counter: saturating up-counter with synchronous clear.
//   clk   - rising-edge clock
//   reset - synchronous active-low reset (count <= 0)
//   clear - synchronous clear, wins over inc
//   inc   - increment request; ignored once count == LIMIT
//   count - current count
module sat_counter #(
    parameter int WIDTH = 4,
    parameter int LIMIT = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    localparam logic [WIDTH-1:0] LIM = WIDTH'(LIMIT);

    always_ff @(posedge clk) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc && (count != LIM)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates a single-port data memory between the CPU MEM stage
// and a boot/DMA loader.
//   clk, reset               - clock, synchronous active-low reset
//   cpu_req/we/addr/wdata    - CPU access request
//   cpu_rdata, cpu_stall     - CPU read data (0 unless granted), stall
//   ld_valid/we/addr/wdata   - loader request; ld_ready is its grant
//   ld_rvalid, ld_rdata      - registered loader read response
//   ld_done                  - one-cycle pulse ending the boot load
//   mem_*                    - data-memory strobes, address, data
//   state, starve_cnt        - debug view of arbiter mode and starvation count
//
// Handshake: the loader transfer happens in any cycle with ld_valid & ld_ready;
// ld_ready may depend combinationally on ld_valid and cpu_req. The CPU is served
// in any cycle with cpu_req & !cpu_stall. Writes land in memory at the grant
// edge; loader read data comes back one cycle later as a one-cycle ld_rvalid.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = DEFAULT_STARVE_LIMIT,
    parameter bit BOOT_EN      = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        cpu_stall,
    input  logic        ld_valid,
    input  logic        ld_we,
    input  logic [31:0] ld_addr,
    input  logic [31:0] ld_wdata,
    output logic        ld_ready,
    output logic        ld_rvalid,
    output logic [31:0] ld_rdata,
    input  logic        ld_done,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic        state,
    output logic [3:0]  starve_cnt
);

    localparam arb_state_t RESET_STATE = BOOT_EN ? ST_BOOT : ST_RUN;

    arb_state_t state_q;
    arb_state_t state_d;
    arb_state_t eff_state;
    logic       grant_ld;
    logic       grant_cpu;
    logic       starve_hit;

    // ------------------------------------------------------------------
    // Mode register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= RESET_STATE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if ((state_q == ST_BOOT) && ld_done) begin
            state_d = ST_RUN;
        end
    end

    // While reset is held the register may not yet reflect the reset state,
    // so the combinational rules are evaluated against the reset state.
    assign eff_state = reset ? state_q : RESET_STATE;

    // ------------------------------------------------------------------
    // Starvation counter: counts consecutive cycles the loader waits
    // ------------------------------------------------------------------
    sat_counter #(
        .WIDTH (4),
        .LIMIT (STARVE_LIMIT)
    ) u_starve (
        .clk   (clk),
        .reset (reset),
        .clear (grant_ld | ~ld_valid),
        .inc   (ld_valid & ~grant_ld),
        .count (starve_cnt)
    );

    assign starve_hit = (starve_cnt == 4'(STARVE_LIMIT));

    // ------------------------------------------------------------------
    // Grant and memory-side mux; grants are mutually exclusive by
    // construction (grant_cpu requires !grant_ld).
    // ------------------------------------------------------------------
    always_comb begin
        grant_ld  = 1'b0;
        grant_cpu = 1'b0;
        if (eff_state == ST_BOOT) begin
            grant_ld = ld_valid;
        end else begin
            grant_ld  = ld_valid & (~cpu_req | starve_hit);
            grant_cpu = cpu_req & ~grant_ld;
        end
    end

    always_comb begin
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        cpu_rdata = '0;
        if (grant_ld) begin
            mem_read  = ~ld_we;
            mem_write = ld_we;
            mem_addr  = ld_addr;
            mem_wdata = ld_wdata;
        end else if (grant_cpu) begin
            mem_read  = ~cpu_we;
            mem_write = cpu_we;
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
            cpu_rdata = mem_rdata;
        end
    end

    // In BOOT this reduces to cpu_req; in RUN to cpu_req & grant_ld.
    assign cpu_stall = cpu_req & ~grant_cpu;
    assign ld_ready  = grant_ld;
    assign state     = state_q;

    // ------------------------------------------------------------------
    // Loader read response
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            ld_rvalid <= 1'b0;
            ld_rdata  <= '0;
        end else begin
            ld_rvalid <= grant_ld & ~ld_we;
            if (grant_ld && !ld_we) begin
                ld_rdata <= mem_rdata;
            end
        end
    end

endmodule
